// File: rtl/multiplier_seq_controller.sv
// Sequencer for a nibble-serial multiplier built around one 4x4 multiplier.
// Walks every (A nibble, B nibble) pair with B as the inner loop, steering
// the operand muxes, the partial-product shifter and the accumulator.
// All outputs are decoded from registered state and counters only.
module multiplier_seq_controller #(
  parameter int WIDTH = 8,
  localparam int NIB  = WIDTH / 4,
  localparam int SELW = (NIB > 1) ? $clog2(NIB) : 1,
  localparam int SHW  = ((2 * NIB - 1) > 1) ? $clog2(2 * NIB - 1) : 1
) (
  input  logic            clk,
  input  logic            reset_a,
  input  logic            start,
  input  logic            abort,
  output logic [SELW-1:0] a_sel,
  output logic [SELW-1:0] b_sel,
  output logic [SHW-1:0]  shift_sel,
  output logic            clk_ena,
  output logic            sclr_n,
  output logic            done,
  output logic            busy,
  output logic            err,
  output logic [2:0]      state_out
);

  // Only whole-nibble operands between one and four bytes are supported.
  if ((WIDTH % 4 != 0) || (WIDTH < 8) || (WIDTH > 32)) begin : gBadWidth
    $error("multiplier_seq_controller: WIDTH must be a multiple of 4 in 8..32");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    CALC  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } stateT;

  localparam logic [SELW-1:0] LAST = SELW'(NIB - 1);

  stateT           r_state;
  stateT           w_nextState;
  logic [SELW-1:0] r_i;
  logic [SELW-1:0] r_j;
  logic            w_lastCalc;

  assign w_lastCalc = (r_i == LAST) && (r_j == LAST);

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Nibble counters: held at zero outside CALC so CLEAR always starts them at
  // (0,0); j is the inner loop and carries into i when it wraps.
  always_ff @(posedge clk) begin
    if (reset_a || (r_state != CALC)) begin
      r_i <= '0;
      r_j <= '0;
    end else if (r_j == LAST) begin
      r_j <= '0;
      r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
    end else begin
      r_j <= r_j + 1'b1;
    end
  end

  // Next-state logic: abort beats start, and start outside IDLE is an error.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start && !abort) w_nextState = CLEAR;
      end
      CLEAR: begin
        if (abort)      w_nextState = IDLE;
        else if (start) w_nextState = ERR;
        else            w_nextState = CALC;
      end
      CALC: begin
        if (abort)           w_nextState = IDLE;
        else if (start)      w_nextState = ERR;
        else if (w_lastCalc) w_nextState = DONE;
      end
      DONE: begin
        if (abort)      w_nextState = IDLE;
        else if (start) w_nextState = ERR;
        else            w_nextState = IDLE;
      end
      ERR: begin
        if (abort) w_nextState = IDLE;
      end
      default: w_nextState = ERR;
    endcase
  end

  // Moore output decode; selects are forced to zero outside CALC.
  always_comb begin
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    done      = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    a_sel     = '0;
    b_sel     = '0;
    shift_sel = '0;
    case (r_state)
      CLEAR: begin
        clk_ena = 1'b1;
        sclr_n  = 1'b0;
        busy    = 1'b1;
      end
      CALC: begin
        clk_ena   = 1'b1;
        busy      = 1'b1;
        a_sel     = r_i;
        b_sel     = r_j;
        shift_sel = SHW'(r_i) + SHW'(r_j);
      end
      DONE: begin
        done = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_out = r_state;

endmodule
